// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequencer for a MIPS-style MULT/MULTU that drives an
// external 2-stage registered unsigned 32x32 multiplier. It also owns the
// HI/LO architectural registers.
//
// Operands are converted to magnitudes before they are issued. The sign is
// reapplied to the 64-bit product when HI/LO are loaded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, is_signed  multiply request; sampled only in IDLE
//   op_a, op_b        32-bit operands; sampled with start
//   mthi, mtlo, wdata direct HI/LO writes; ignored while busy
//   mul_a, mul_b      registered operand magnitudes to the multiplier
//   mul_r             multiplier product; valid 2 edges after mul_a/mul_b
//   busy              a multiply is in flight (ISSUE/WAIT/CAPTURE)
//   done              one-cycle pulse after HI/LO took the product
//   hi, lo            HI/LO registers
module mult_hilo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_r,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  logic [1:0]  state;
  logic        neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod;

  // Two's-complement negation of 0x80000000 gives 0x80000000 back. Read as
  // unsigned, that is the correct magnitude 2^31, so no special case is needed.
  assign mag_a = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign mag_b = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
  assign prod  = neg ? (64'd0 - mul_r) : mul_r;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      neg   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == CAPTURE);
      // Direct writes apply in IDLE only. A multiply started on the same edge
      // overwrites them later, at CAPTURE.
      if (!busy) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
      case (state)
        IDLE: if (start) begin
          mul_a <= mag_a;
          mul_b <= mag_b;
          neg   <= is_signed & (op_a[31] ^ op_b[31]);
          state <= ISSUE;
        end
        ISSUE:   state <= WAIT;
        WAIT:    state <= CAPTURE;
        CAPTURE: begin
          {hi, lo} <= prod;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
